// File: rtl/audio_nios_i2c_pkg.sv
// audio_nios_i2c_pkg
// Shared definitions for the Nios audio I2C loopback target:
//   - i2c_state_t : protocol FSM states (also exported on the debug port)
//   - I2C_ACK / I2C_NACK : SDA levels of the acknowledge bit
//   - BIT_CNT_W : width of the per-byte bit counter (counts 0..8)
package audio_nios_i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RACK      = 4'd8,
      ST_IGNORE    = 4'd9
   } i2c_state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/audio_nios_i2c_filter.sv
// audio_nios_i2c_filter
// Brings one asynchronous I2C pin into the clk domain and removes glitches.
// A 2-flop synchronizer feeds a deglitcher that only accepts a new level
// after FILTER_LEN consecutive equal samples that differ from the current
// output. Pin-to-output latency is 2 + FILTER_LEN clk cycles.
// Ports:
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset (output resets to 1 = bus idle)
//   i_pin    in  raw pin level
//   o_level  out filtered level
module audio_nios_i2c_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_pin,
   output logic o_level
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync  <= 2'b11;
         r_cnt   <= '0;
         r_level <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], i_pin};
         // Any sample equal to the accepted level restarts the run, so a
         // pulse shorter than FILTER_LEN samples never reaches the output.
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/audio_nios_i2c_target.sv
// audio_nios_i2c_target
// I2C target answering DEV_ADDR with a NUM_REGS x 8 register bank.
// Write: START, {DEV_ADDR,0}, pointer, data... ; each data byte is stored at
// ptr and ptr auto-increments. Read: START, {DEV_ADDR,1}, data... from ptr
// with auto-increment until the initiator NACKs. SCL is never driven; SDA is
// open-drain (sda_oe=1 pulls low).
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   scl_in, sda_in        raw bus pin levels (asynchronous)
//   sda_oe                1 = pull SDA low
//   wr_valid/addr/data    one-cycle pulse per byte written over I2C
//   host_addr/host_rdata  combinational fabric-side register read
//   busy                  1 between an accepted START and STOP/reset
//   o_dbg_state           current protocol state
module audio_nios_i2c_target
   import audio_nios_i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = 7'h1A,
   parameter int         NUM_REGS   = 16,
   parameter int         FILTER_LEN = 3,
   localparam int        PTR_W      = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             scl_in,
   input  logic             sda_in,
   output logic             sda_oe,
   output logic             wr_valid,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   input  logic [PTR_W-1:0] host_addr,
   output logic [7:0]       host_rdata,
   output logic             busy,
   output i2c_state_t       o_dbg_state
);

   logic w_scl, w_sda;
   logic r_scl_d, r_sda_d;
   logic w_scl_rise, w_scl_fall, w_start, w_stop;

   i2c_state_t           r_state, w_state_nxt;
   logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [6:0]           r_shift, w_shift_nxt;
   logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
   logic                 r_sda_oe, w_sda_oe_nxt;
   logic                 r_busy, w_busy_nxt;
   logic                 r_wr_valid, w_wr_valid_nxt;
   logic [PTR_W-1:0]     r_wr_addr, w_wr_addr_nxt;
   logic [7:0]           r_wr_data, w_wr_data_nxt;
   logic                 w_reg_we;
   logic [7:0]           w_byte;
   logic [7:0]           w_rd_byte;
   logic [7:0]           r_regs [NUM_REGS];

   audio_nios_i2c_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .i_pin   (scl_in),
      .o_level (w_scl)
   );

   audio_nios_i2c_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .i_pin   (sda_in),
      .o_level (w_sda)
   );

   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

   // Received byte including the bit arriving on this SCL rise.
   assign w_byte    = {r_shift, w_sda};
   assign w_rd_byte = r_regs[r_ptr];

   // Bit counter usage: in receive states it counts SCL rises 0..8. On entry
   // to an *_ACK state it holds 8, meaning "ACK not yet driven"; the first
   // SCL fall drives ACK and clears it, the next fall ends the ACK slot.
   // In RDATA it counts rises; RACK holds 8 until an ACK rise clears it.
   // In RDATA/RACK r_shift holds the not-yet-sent bits of the read byte.
   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_ptr_nxt      = r_ptr;
      w_sda_oe_nxt   = r_sda_oe;
      w_busy_nxt     = r_busy;
      w_wr_valid_nxt = 1'b0;
      w_wr_addr_nxt  = r_wr_addr;
      w_wr_data_nxt  = r_wr_data;
      w_reg_we       = 1'b0;

      if (w_stop) begin
         w_state_nxt   = ST_IDLE;
         w_bit_cnt_nxt = '0;
         w_sda_oe_nxt  = 1'b0;
         w_busy_nxt    = 1'b0;
      end else if (w_start) begin
         w_state_nxt   = ST_ADDR;
         w_bit_cnt_nxt = '0;
         w_sda_oe_nxt  = 1'b0;
         w_busy_nxt    = 1'b1;
      end else begin
         case (r_state)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (w_scl_rise) begin
                  w_shift_nxt   = w_byte[6:0];
                  w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                  if (r_bit_cnt == BIT_CNT_W'(7)) begin
                     if (r_state == ST_ADDR) begin
                        // R/W bit stays in r_shift[0] through ADDR_ACK.
                        if (w_byte[7:1] == DEV_ADDR) w_state_nxt = ST_ADDR_ACK;
                        else                         w_state_nxt = ST_IGNORE;
                     end else if (r_state == ST_PTR) begin
                        w_ptr_nxt   = w_byte[PTR_W-1:0];
                        w_state_nxt = ST_PTR_ACK;
                     end else begin
                        w_reg_we       = 1'b1;
                        w_wr_valid_nxt = 1'b1;
                        w_wr_addr_nxt  = r_ptr;
                        w_wr_data_nxt  = w_byte;
                        w_ptr_nxt      = r_ptr + 1'b1;
                        w_state_nxt    = ST_WDATA_ACK;
                     end
                  end
               end
            end

            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (w_scl_fall) begin
                  w_bit_cnt_nxt = '0;
                  if (r_bit_cnt == BIT_CNT_W'(8)) begin
                     w_sda_oe_nxt = ~I2C_ACK;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     if (r_state == ST_ADDR_ACK && r_shift[0]) begin
                        // First read bit goes out on the fall ending the ACK.
                        w_state_nxt  = ST_RDATA;
                        w_shift_nxt  = w_rd_byte[6:0];
                        w_sda_oe_nxt = ~w_rd_byte[7];
                     end else if (r_state == ST_ADDR_ACK) begin
                        w_state_nxt = ST_PTR;
                     end else begin
                        w_state_nxt = ST_WDATA;
                     end
                  end
               end
            end

            ST_RDATA: begin
               if (w_scl_rise) begin
                  w_bit_cnt_nxt = r_bit_cnt + 1'b1;
               end else if (w_scl_fall) begin
                  if (r_bit_cnt == BIT_CNT_W'(8)) begin
                     // Byte done: free SDA for the initiator's ACK/NACK.
                     w_sda_oe_nxt = 1'b0;
                     w_ptr_nxt    = r_ptr + 1'b1;
                     w_state_nxt  = ST_RACK;
                  end else begin
                     w_sda_oe_nxt = ~r_shift[6];
                     w_shift_nxt  = {r_shift[5:0], 1'b0};
                  end
               end
            end

            ST_RACK: begin
               if (w_scl_rise) begin
                  if (w_sda == I2C_NACK) w_state_nxt = ST_IGNORE;
                  else                   w_bit_cnt_nxt = '0;
               end else if (w_scl_fall && r_bit_cnt == '0) begin
                  w_state_nxt  = ST_RDATA;
                  w_shift_nxt  = w_rd_byte[6:0];
                  w_sda_oe_nxt = ~w_rd_byte[7];
               end
            end

            default: begin
               // IDLE and IGNORE only leave on START/STOP.
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
         r_state    <= ST_IDLE;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_ptr      <= '0;
         r_sda_oe   <= 1'b0;
         r_busy     <= 1'b0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
         r_state    <= w_state_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_ptr      <= w_ptr_nxt;
         r_sda_oe   <= w_sda_oe_nxt;
         r_busy     <= w_busy_nxt;
         r_wr_valid <= w_wr_valid_nxt;
         r_wr_addr  <= w_wr_addr_nxt;
         r_wr_data  <= w_wr_data_nxt;
         if (w_reg_we) r_regs[r_ptr] <= w_byte;
      end
   end

   assign sda_oe      = r_sda_oe;
   assign wr_valid    = r_wr_valid;
   assign wr_addr     = r_wr_addr;
   assign wr_data     = r_wr_data;
   assign busy        = r_busy;
   assign host_rdata  = r_regs[host_addr];
   assign o_dbg_state = r_state;

endmodule
